// File: rtl/jtag_tap_ctrl_if.sv
// Pin and chain-side signals of the TAP controller. The controller connects through
// the master modport. The pad/chain side connects through the slave modport.
interface jtag_tap_ctrl_if;
    logic tms_i;
    logic tdi_i;
    logic bs_chain_tdo_i;
    logic mbist_tdo_i;
    logic debug_tdo_i;
    logic test_logic_reset_o;
    logic capture_dr_o;
    logic shift_dr_o;
    logic pause_dr_o;
    logic update_dr_o;
    logic extest_select_o;
    logic sample_preload_select_o;
    logic mbist_select_o;
    logic debug_select_o;
    logic tdo_o;
    logic tdo_oe_o;

    modport master (
        input  tms_i, tdi_i, bs_chain_tdo_i, mbist_tdo_i, debug_tdo_i,
        output test_logic_reset_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
        output extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o,
        output tdo_o, tdo_oe_o
    );

    modport slave (
        output tms_i, tdi_i, bs_chain_tdo_i, mbist_tdo_i, debug_tdo_i,
        input  test_logic_reset_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
        input  extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o,
        input  tdo_o, tdo_oe_o
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, IDCODE/BYPASS
// data registers and the falling-edge TDO mux for the downstream scan chains.
module jtag_tap_ctrl #(
    parameter int                IR_LEN            = 4,
    parameter logic [31:0]       IDCODE_VAL        = 32'h1800_A0B5,
    parameter logic [IR_LEN-1:0] OP_EXTEST         = 4'h0,
    parameter logic [IR_LEN-1:0] OP_IDCODE         = 4'h1,
    parameter logic [IR_LEN-1:0] OP_SAMPLE_PRELOAD = 4'h2,
    parameter logic [IR_LEN-1:0] OP_MBIST          = 4'h8,
    parameter logic [IR_LEN-1:0] OP_DEBUG          = 4'h9,
    parameter logic [IR_LEN-1:0] OP_BYPASS         = 4'hF
) (
    input  logic           tck_i,
    input  logic           trst_n_i,
    jtag_tap_ctrl_if.master tap
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-2){1'b0}}, 2'b01};

    tap_state_e        state_q, state_d;
    logic              tlr_q, capture_q, shift_q, pause_q, update_q;

    logic [IR_LEN-1:0] ir_shift_q;
    logic [IR_LEN-1:0] ir_active_q, ir_active_d;
    logic              extest_sel_q, sample_sel_q, mbist_sel_q, debug_sel_q;

    logic [31:0]       idcode_q;
    logic              bypass_q;
    logic              sel_idcode, sel_bypass;

    logic              tdo_d, tdo_q, tdo_oe_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = tap.tms_i ? TLR      : RTI;
            RTI:      state_d = tap.tms_i ? SEL_DR   : RTI;
            SEL_DR:   state_d = tap.tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tap.tms_i ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tap.tms_i ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tap.tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tap.tms_i ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tap.tms_i ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tap.tms_i ? SEL_DR   : RTI;
            SEL_IR:   state_d = tap.tms_i ? TLR      : CAP_IR;
            CAP_IR:   state_d = tap.tms_i ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tap.tms_i ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tap.tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tap.tms_i ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tap.tms_i ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tap.tms_i ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Strobes are registered from the next state, so they line up exactly with state_q.
    always_ff @(posedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) begin
            state_q   <= TLR;
            tlr_q     <= 1'b1;
            capture_q <= 1'b0;
            shift_q   <= 1'b0;
            pause_q   <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tlr_q     <= (state_d == TLR);
            capture_q <= (state_d == CAP_DR);
            shift_q   <= (state_d == SH_DR);
            pause_q   <= (state_d == PAUSE_DR);
            update_q  <= (state_d == UPD_DR);
        end
    end

    always_comb begin
        ir_active_d = ir_active_q;
        if (state_q == TLR) begin
            ir_active_d = OP_IDCODE;
        end else if (state_q == UPD_IR) begin
            ir_active_d = ir_shift_q;
        end
    end

    always_ff @(posedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) begin
            ir_shift_q   <= '0;
            ir_active_q  <= OP_IDCODE;
            extest_sel_q <= 1'b0;
            sample_sel_q <= 1'b0;
            mbist_sel_q  <= 1'b0;
            debug_sel_q  <= 1'b0;
        end else begin
            if (state_q == CAP_IR) begin
                ir_shift_q <= IR_CAPTURE;
            end else if (state_q == SH_IR) begin
                ir_shift_q <= {tap.tdi_i, ir_shift_q[IR_LEN-1:1]};
            end
            ir_active_q  <= ir_active_d;
            extest_sel_q <= (ir_active_d == OP_EXTEST);
            sample_sel_q <= (ir_active_d == OP_SAMPLE_PRELOAD);
            mbist_sel_q  <= (ir_active_d == OP_MBIST);
            debug_sel_q  <= (ir_active_d == OP_DEBUG);
        end
    end

    // Any opcode that does not name a real chain falls back to the 1-bit bypass path.
    assign sel_idcode = (ir_active_q == OP_IDCODE);
    assign sel_bypass = (ir_active_q == OP_BYPASS) ||
                        !((ir_active_q == OP_EXTEST) || (ir_active_q == OP_SAMPLE_PRELOAD) ||
                          (ir_active_q == OP_MBIST)  || (ir_active_q == OP_DEBUG) || sel_idcode);

    always_ff @(posedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) begin
            idcode_q <= IDCODE_VAL;
            bypass_q <= 1'b0;
        end else begin
            if (state_q == CAP_DR) begin
                if (sel_idcode) idcode_q <= IDCODE_VAL;
                if (sel_bypass) bypass_q <= 1'b0;
            end else if (state_q == SH_DR) begin
                if (sel_idcode) idcode_q <= {tap.tdi_i, idcode_q[31:1]};
                if (sel_bypass) bypass_q <= tap.tdi_i;
            end
        end
    end

    always_comb begin
        tdo_d = tdo_q;
        if (state_q == SH_IR) begin
            tdo_d = ir_shift_q[0];
        end else if (state_q == SH_DR) begin
            if (extest_sel_q || sample_sel_q) tdo_d = tap.bs_chain_tdo_i;
            else if (mbist_sel_q)             tdo_d = tap.mbist_tdo_i;
            else if (debug_sel_q)             tdo_d = tap.debug_tdo_i;
            else if (sel_idcode)              tdo_d = idcode_q[0];
            else                              tdo_d = bypass_q;
        end
    end

    // TDO changes on the falling edge so the far end can sample it on the next rising edge.
    always_ff @(negedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= (state_q == SH_IR) || (state_q == SH_DR);
        end
    end

    assign tap.test_logic_reset_o      = tlr_q;
    assign tap.capture_dr_o            = capture_q;
    assign tap.shift_dr_o              = shift_q;
    assign tap.pause_dr_o              = pause_q;
    assign tap.update_dr_o             = update_q;
    assign tap.extest_select_o         = extest_sel_q;
    assign tap.sample_preload_select_o = sample_sel_q;
    assign tap.mbist_select_o          = mbist_sel_q;
    assign tap.debug_select_o          = debug_sel_q;
    assign tap.tdo_o                   = tdo_q;
    assign tap.tdo_oe_o                = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: a TMS walk table for state strobes, then
// hand-written IR/DR scans, bypass, soft reset and asynchronous reset sequences.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDCODE_EXP = 32'h1800_A0B5;

    typedef struct {
        logic       tms;
        logic [5:0] strobes;
        logic [3:0] sels;
    } vec_t;

    logic tck;
    logic trstN;
    int   compared;
    int   mismatched;
    vec_t vecs[30];

    jtag_tap_ctrl_if bus ();

    jtag_tap_ctrl dut (
        .tck_i   (tck),
        .trst_n_i(trstN),
        .tap     (bus)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // One TCK cycle; returns just after the falling edge so TDO and strobes are settled.
    task automatic applyStimulus(input logic tms, input logic tdi);
        bus.tms_i = tms;
        bus.tdi_i = tdi;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.test_logic_reset_o, bus.capture_dr_o, bus.shift_dr_o,
                bus.pause_dr_o, bus.update_dr_o, bus.tdo_oe_o};
    endfunction

    function automatic logic [3:0] sels();
        return {bus.extest_select_o, bus.sample_preload_select_o,
                bus.mbist_select_o, bus.debug_select_o};
    endfunction

    task automatic setChains(input logic bs, input logic mb, input logic db);
        bus.bs_chain_tdo_i = bs;
        bus.mbist_tdo_i    = mb;
        bus.debug_tdo_i    = db;
    endtask

    // From RTI: load an opcode, returning the captured bits seen on TDO. Ends in RTI.
    task automatic loadIr(input logic [3:0] op, output logic [3:0] cap);
        cap = '0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cap[i] = bus.tdo_o;
            applyStimulus(i == 3, op[i]);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    // From RTI: n-bit DR scan; oeOk is set if OE was high throughout and low at Exit1-DR.
    task automatic shiftDr(input int n, input logic [31:0] din, input logic [31:0] bsPat,
                           input logic [31:0] mbPat, input logic [31:0] dbPat,
                           output logic [31:0] dout, output logic oeOk);
        dout = '0;
        oeOk = 1'b1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        setChains(bsPat[0], mbPat[0], dbPat[0]);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = bus.tdo_o;
            oeOk    = oeOk & bus.tdo_oe_o;
            if (i + 1 < n) setChains(bsPat[i+1], mbPat[i+1], dbPat[i+1]);
            applyStimulus(i == n - 1, din[i]);
        end
        oeOk = oeOk & ~bus.tdo_oe_o;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0]  cap;
        logic [31:0] dout;
        logic        oeOk;

        compared   = 0;
        mismatched = 0;
        trstN      = 1'b0;
        bus.tms_i  = 1'b1;
        bus.tdi_i  = 1'b0;
        setChains(1'b0, 1'b0, 1'b0);

        // {tms, {tlr,capture,shift,pause,update,oe}, {extest,sample,mbist,debug}} after each edge
        vecs[0]  = '{1'b1, 6'b100000, 4'b0000};
        vecs[1]  = '{1'b0, 6'b000000, 4'b0000};
        vecs[2]  = '{1'b0, 6'b000000, 4'b0000};
        vecs[3]  = '{1'b1, 6'b000000, 4'b0000};
        vecs[4]  = '{1'b0, 6'b010000, 4'b0000};
        vecs[5]  = '{1'b0, 6'b001001, 4'b0000};
        vecs[6]  = '{1'b0, 6'b001001, 4'b0000};
        vecs[7]  = '{1'b0, 6'b001001, 4'b0000};
        vecs[8]  = '{1'b1, 6'b000000, 4'b0000};
        vecs[9]  = '{1'b0, 6'b000100, 4'b0000};
        vecs[10] = '{1'b0, 6'b000100, 4'b0000};
        vecs[11] = '{1'b1, 6'b000000, 4'b0000};
        vecs[12] = '{1'b0, 6'b001001, 4'b0000};
        vecs[13] = '{1'b1, 6'b000000, 4'b0000};
        vecs[14] = '{1'b1, 6'b000010, 4'b0000};
        vecs[15] = '{1'b1, 6'b000000, 4'b0000};
        vecs[16] = '{1'b1, 6'b000000, 4'b0000};
        vecs[17] = '{1'b0, 6'b000000, 4'b0000};
        vecs[18] = '{1'b0, 6'b000001, 4'b0000};
        vecs[19] = '{1'b1, 6'b000000, 4'b0000};
        vecs[20] = '{1'b0, 6'b000000, 4'b0000};
        vecs[21] = '{1'b1, 6'b000000, 4'b0000};
        vecs[22] = '{1'b0, 6'b000001, 4'b0000};
        vecs[23] = '{1'b1, 6'b000000, 4'b0000};
        vecs[24] = '{1'b1, 6'b000000, 4'b0000};
        vecs[25] = '{1'b0, 6'b000000, 4'b1000};
        vecs[26] = '{1'b1, 6'b000000, 4'b1000};
        vecs[27] = '{1'b1, 6'b000000, 4'b1000};
        vecs[28] = '{1'b1, 6'b100000, 4'b1000};
        vecs[29] = '{1'b1, 6'b100000, 4'b0000};

        repeat (2) @(negedge tck);
        #1;
        checkOutput("reset_strobes", 32'(strobes()), 32'(6'b100000));
        checkOutput("reset_sels", 32'(sels()), 32'h0);
        checkOutput("reset_tdo", 32'(bus.tdo_o), 32'h0);
        trstN = 1'b1;

        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i].tms, 1'b0);
            checkOutput($sformatf("walk%0d_strobes", i), 32'(strobes()), 32'(vecs[i].strobes));
            checkOutput($sformatf("walk%0d_sels", i), 32'(sels()), 32'(vecs[i].sels));
        end

        applyStimulus(1'b0, 1'b0);
        shiftDr(32, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, dout, oeOk);
        checkOutput("idcode_read", dout, IDCODE_EXP);
        checkOutput("idcode_oe", 32'(oeOk), 32'h1);

        loadIr(4'h0, cap);
        checkOutput("extest_ir_capture", 32'(cap), 32'h1);
        checkOutput("extest_sels", 32'(sels()), 32'(4'b1000));
        shiftDr(8, 32'h0F, 32'h0000_00A6, 32'h0000_00FF, 32'h0, dout, oeOk);
        checkOutput("extest_route", dout, 32'h0000_00A6);

        loadIr(4'h2, cap);
        checkOutput("sample_sels", 32'(sels()), 32'(4'b0100));
        shiftDr(8, 32'h0, 32'h0000_0039, 32'h0, 32'h0000_00FF, dout, oeOk);
        checkOutput("sample_route", dout, 32'h0000_0039);

        loadIr(4'h8, cap);
        checkOutput("mbist_sels", 32'(sels()), 32'(4'b0010));
        shiftDr(8, 32'h0, 32'h0000_00FF, 32'h0000_005C, 32'h0000_00FF, dout, oeOk);
        checkOutput("mbist_route", dout, 32'h0000_005C);

        loadIr(4'h9, cap);
        checkOutput("debug_sels", 32'(sels()), 32'(4'b0001));
        shiftDr(8, 32'h0, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00C3, dout, oeOk);
        checkOutput("debug_route", dout, 32'h0000_00C3);

        loadIr(4'hF, cap);
        checkOutput("bypass_ir_capture", 32'(cap), 32'h1);
        checkOutput("bypass_sels", 32'(sels()), 32'h0);
        shiftDr(8, 32'h0000_00B2, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, dout, oeOk);
        checkOutput("bypass_data", dout, 32'h0000_0064);
        checkOutput("bypass_oe", 32'(oeOk), 32'h1);

        loadIr(4'h5, cap);
        checkOutput("unknown_sels", 32'(sels()), 32'h0);
        shiftDr(8, 32'h0000_00B2, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, dout, oeOk);
        checkOutput("unknown_bypass_data", dout, 32'h0000_0064);

        // Five TMS=1 edges from Shift-DR land in TLR; the next edge there restores IDCODE.
        loadIr(4'h9, cap);
        checkOutput("soft_debug_sels", 32'(sels()), 32'(4'b0001));
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("soft_tlr_strobes", 32'(strobes()), 32'(6'b100000));
        applyStimulus(1'b1, 1'b0);
        checkOutput("soft_sels", 32'(sels()), 32'h0);
        applyStimulus(1'b0, 1'b0);
        shiftDr(32, 32'h0, 32'h0, 32'h0, 32'h0, dout, oeOk);
        checkOutput("soft_idcode", dout, IDCODE_EXP);

        // Asynchronous reset in the middle of a debug-chain scan.
        loadIr(4'h9, cap);
        setChains(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("pre_trst_tdo", 32'(bus.tdo_o), 32'h1);
        checkOutput("pre_trst_strobes", 32'(strobes()), 32'(6'b001001));
        #2;
        trstN = 1'b0;
        #1;
        checkOutput("trst_strobes", 32'(strobes()), 32'(6'b100000));
        checkOutput("trst_sels", 32'(sels()), 32'h0);
        checkOutput("trst_tdo", 32'(bus.tdo_o), 32'h0);
        @(negedge tck);
        #1;
        trstN = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_trst_rti", 32'(strobes()), 32'h0);
        checkOutput("post_trst_sels", 32'(sels()), 32'h0);
        shiftDr(32, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, dout, oeOk);
        checkOutput("post_trst_idcode", dout, IDCODE_EXP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
